// File: rtl/pmod_clkgen.sv
// Multi-channel programmable clock/strobe generator for PMOD pins.
// Each channel divides sysclk by 2(N+1); divisor changes are applied only on toggle boundaries or sync.
module pmod_clkgen #(
   parameter int CHANNELS    = 4,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 0
) (
   input  logic                 sysclk,
   input  logic                 rst,
   input  logic [CHANNELS-1:0]  en,
   input  logic                 sync,
   input  logic                 div_we,
   input  logic [3:0]           div_sel,
   input  logic [DIV_WIDTH-1:0] div_data,
   output logic [CHANNELS-1:0]  pmod_pin,
   output logic [CHANNELS-1:0]  tick
);

   localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

   logic [DIV_WIDTH-1:0] cnt_q [CHANNELS];
   logic [DIV_WIDTH-1:0] cnt_d [CHANNELS];
   logic [DIV_WIDTH-1:0] act_q [CHANNELS];
   logic [DIV_WIDTH-1:0] act_d [CHANNELS];
   logic [DIV_WIDTH-1:0] shd_q [CHANNELS];
   logic [DIV_WIDTH-1:0] shd_d [CHANNELS];
   logic [CHANNELS-1:0]  out_q, out_d;
   logic [CHANNELS-1:0]  tick_q, tick_d;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i]  = cnt_q[i];
         act_d[i]  = act_q[i];
         shd_d[i]  = shd_q[i];
         out_d[i]  = out_q[i];
         tick_d[i] = 1'b0;

         // Out-of-range selects never match any channel, so such writes vanish.
         if (div_we && (div_sel == 4'(i))) begin
            shd_d[i] = div_data;
         end

         // cnt never exceeds act_q: act_q only changes when cnt restarts at 0.
         if (sync) begin
            cnt_d[i] = '0;
            out_d[i] = 1'b0;
            act_d[i] = shd_q[i];
         end else if (!en[i]) begin
            cnt_d[i] = '0;
            out_d[i] = 1'b0;
         end else if (cnt_q[i] == act_q[i]) begin
            cnt_d[i]  = '0;
            out_d[i]  = ~out_q[i];
            act_d[i]  = shd_q[i];
            tick_d[i] = ~out_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
            act_q[i] <= DEF_DIV;
            shd_q[i] <= DEF_DIV;
         end
         out_q  <= '0;
         tick_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
            act_q[i] <= act_d[i];
            shd_q[i] <= shd_d[i];
         end
         out_q  <= out_d;
         tick_q <= tick_d;
      end
   end

   assign pmod_pin = out_q;
   assign tick     = tick_q;

endmodule

// File: doc/pmod_clkgen.md
Name: pmod_clkgen

Overview:
- Parametrised multi-channel clock/strobe generator driving PMOD pins from sysclk.
- Each channel has a runtime-programmable divider, an enable and a one-cycle tick on each rising output edge.
- A global sync input phase-aligns all channels.
- All outputs are registered, so no combinational path exists from sysclk to a pin.
- Used to produce scope-visible and peripheral clocks for lab experiments.

Parameters:
- CHANNELS, 4, number of independent output channels (1..16).
- DIV_WIDTH, 16, width of each channel's half-period divisor.
- DEFAULT_DIV, 0, divisor loaded into every channel at reset; 0 gives sysclk/2.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  CHANNELS  per-channel enable; bit i enables channel i.
- sync  in  1  one-cycle pulse that restarts all channels in phase.
- div_we  in  1  divisor write strobe.
- div_sel  in  4  channel index for the write.
- div_data  in  DIV_WIDTH  new half-period divisor N.
- pmod_pin  out  CHANNELS  generated clock outputs.
- tick  out  CHANNELS  one-cycle pulse marking each pmod_pin rising edge.

Behaviour:
- Per-channel state:
  - cnt[DIV_WIDTH]
  - active_div[DIV_WIDTH]
  - shadow_div[DIV_WIDTH]
  - out (drives pmod_pin[i])
  - tick register
- Reset, asynchronous on rst high:
  - cnt=0, out=0, tick=0.
  - active_div=shadow_div=DEFAULT_DIV.
  - pmod_pin and tick read 0 while rst is high and on the first cycle after release.
- Division:
  - out toggles every N+1 enabled cycles.
  - Period = 2(N+1) sysclk cycles; duty cycle is exactly 50%.
  - N=0 gives sysclk/2. N = 2^DIV_WIDTH-1 must work, with no overflow of cnt.
- Per-cycle update, priority order:
  1. sync=1: all channels set cnt=0, out=0, tick=0 and active_div=shadow_div (the pre-write shadow value).
  2. en[i]=0: cnt=0, out=0, tick=0; shadow_div and active_div are retained.
  3. en[i]=1 and cnt==active_div: cnt=0, out=~out, active_div=shadow_div; tick=1 if out goes 0->1, else tick=0.
  4. Otherwise: cnt=cnt+1, tick=0.
- tick timing:
  - tick is registered and high in the same cycle pmod_pin first reads 1.
  - It lasts exactly one cycle.
- Divisor write:
  - On div_we=1 with div_sel<CHANNELS, shadow_div[div_sel]=div_data.
  - div_sel>=CHANNELS: the write is silently ignored.
  - A new divisor takes effect only at the next toggle boundary or sync, so there are no glitches or runt pulses.
  - Write in the same cycle as a boundary: the boundary loads the old shadow value; the new value applies at the following boundary.
  - Write in the same cycle as sync: sync loads the old shadow value; the shadow takes the new value.
- Enable timing:
  - Enable from idle: the first rising edge of pmod_pin occurs N+1 cycles after the first cycle en is sampled high.
  - Disable mid-period: pmod_pin reads 0 on the next cycle; there is no completion of the current half-period.
- Reset mid-operation: all channels return to the reset state immediately, regardless of en or sync.
- Channels are fully independent except for the shared sync and shared write port.

Test Plan:
- Reset release, DEFAULT_DIV=0, en=4'b0001 → pmod_pin[0] toggles every cycle (sysclk/2); tick[0] high every 2nd cycle; other pins stay 0.
- Write div_sel=1, div_data=2, then en[1]=1 → pmod_pin[1] period 6 cycles, 3 high / 3 low; first rise 3 cycles after en sampled; one tick per period.
- Channel 2 running at N=4; write N=1 mid-half-period → current half-period completes at 5 cycles, then half-periods of 2; no pulse shorter than 2 cycles.
- Channels 0–3 with N=0,1,2,3, all enabled; pulse sync → every pmod_pin reads 0 the next cycle; all rise together 1,2,3,4 cycles later respectively (each N+1).
- Write with div_sel=7 (CHANNELS=4) → no shadow_div changes; all output periods unchanged.
- Assert rst asynchronously mid-high phase → pmod_pin and tick go 0 without waiting for a clock edge; divisors return to DEFAULT_DIV; deasserting en mid-period gives pmod_pin=0 the next cycle.
